// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-arbiter-side signals of dcache_nway.
// The cache uses the slave modport; the pipeline/arbiter side uses master.
interface dcache_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_grant;
    logic        memory_read_en;
    logic        memory_write_en;
    logic [15:0] memory_address;
    logic [15:0] memory_data_out;
    logic        memory_data_valid;
    logic [15:0] memory_data_in;
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_grant, memory_data_valid, memory_data_in,
        input  cpu_ready, cpu_rdata, busy, mem_req, memory_read_en, memory_write_en,
               memory_address, memory_data_out
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_grant, memory_data_valid, memory_data_in,
        output cpu_ready, cpu_rdata, busy, mem_req, memory_read_en, memory_write_en,
               memory_address, memory_data_out
    );
endinterface

// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative write-through, write-allocate data cache with true LRU.
// Defining DCACHE_PERF_CNT_EN adds saturating perf_hits/perf_misses outputs.
module dcache_nway #(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int WORDS = 8
) (
    input logic clk,
    input logic rst,
    dcache_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0] perf_hits,
    output logic [15:0] perf_misses
`endif
);
    localparam int CW    = $clog2(WORDS);
    localparam int OFF_W = CW + 1;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 16 - IDX_W - OFF_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [2:0] IDLE = 3'd0, TAG = 3'd1, MEMWR = 3'd2, FILL = 3'd3, REFILL = 3'd4;

    logic [15:0]      data  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0] tags  [WAYS][SETS];
    logic [WAYS-1:0]  valid [SETS];
    logic [WW-1:0]    age   [WAYS][SETS];

    logic [2:0]       state;
    logic [15:1]      addr;
    logic [15:0]      wdata;
    logic             we, wr_done, refill;
    logic [CW:0]      iss;
    logic [CW-1:0]    rsp;
    logic [WW-1:0]    vic, vic_sel, hit_way, lru_way, age_hit;
    logic             hit, tag_st, rd_hit, wr_en, rd_en, beat, fill_done, lru_en;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [CW-1:0]    word;

    assign tag  = addr[15 -: TAG_W];
    assign idx  = addr[OFF_W +: IDX_W];
    assign word = addr[1 +: CW];

    // Descending scans let the lowest matching way win.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        vic_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx][w] && tags[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
            if (age[w][idx] == WW'(WAYS - 1)) vic_sel = WW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[idx][w]) vic_sel = WW'(w);
    end

    assign tag_st    = state == TAG;
    assign rd_hit    = tag_st && hit && !we;
    assign wr_en     = state == MEMWR && !wr_done && bus.mem_grant;
    assign rd_en     = state == FILL && bus.mem_grant && !iss[CW];
    assign beat      = state == FILL && bus.memory_data_valid;
    assign fill_done = beat && rsp == CW'(WORDS - 1);
    assign lru_en    = (tag_st && hit) || fill_done;
    assign lru_way   = tag_st ? hit_way : vic;
    assign age_hit   = age[lru_way][idx];

    assign bus.busy            = state != IDLE;
    assign bus.cpu_ready       = rd_hit || (state == MEMWR && wr_done);
    assign bus.cpu_rdata       = rd_hit ? data[hit_way][idx][word] : '0;
    assign bus.mem_req         = (state == MEMWR && !wr_done) || state == FILL;
    assign bus.memory_read_en  = rd_en;
    assign bus.memory_write_en = wr_en;
    assign bus.memory_address  = wr_en ? {addr, 1'b0} : rd_en ? {tag, idx, iss[CW-1:0], 1'b0} : '0;
    assign bus.memory_data_out = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            wdata <= '0;
            we <= 1'b0;
            wr_done <= 1'b0;
            refill <= 1'b0;
            iss <= '0;
            rsp <= '0;
            vic <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[w][s] <= WW'(w);
            end
        end else begin
            case (state)
                IDLE: if (bus.cpu_req) begin
                    addr <= bus.cpu_addr[15:1];
                    we <= bus.cpu_we;
                    wdata <= bus.cpu_wdata;
                    state <= TAG;
                end
                TAG: begin
                    refill <= 1'b0;
                    wr_done <= 1'b0;
                    iss <= '0;
                    rsp <= '0;
                    vic <= vic_sel;
                    state <= hit ? (we ? MEMWR : IDLE) : FILL;
                end
                MEMWR: begin
                    wr_done <= wr_done || wr_en;
                    state <= wr_done ? IDLE : MEMWR;
                end
                FILL: begin
                    iss <= iss + (CW + 1)'(rd_en);
                    rsp <= rsp + CW'(beat);
                    if (fill_done) begin
                        valid[idx][vic] <= 1'b1;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    refill <= 1'b1;
                    state <= TAG;
                end
                default: state <= IDLE;
            endcase
            // Accessed way becomes youngest; only younger ways age, so ages stay a permutation.
            if (lru_en)
                for (int w = 0; w < WAYS; w++)
                    age[w][idx] <= WW'(w) == lru_way ? '0 : age[w][idx] < age_hit ? age[w][idx] + 1'b1 : age[w][idx];
        end
    end

    always_ff @(posedge clk) begin
        if (beat) data[vic][idx][rsp] <= bus.memory_data_in;
        if (tag_st && hit && we) data[hit_way][idx][word] <= wdata;
        if (fill_done) tags[vic][idx] <= tag;
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits <= '0;
            perf_misses <= '0;
        end else begin
            if (tag_st && hit && !refill && perf_hits != 16'hFFFF) perf_hits <= perf_hits + 16'd1;
            if (tag_st && !hit && perf_misses != 16'hFFFF) perf_misses <= perf_misses + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: directed test of dcache_nway (defaults) against a 4-cycle-latency memory model.
// Memory word at byte address a starts as a ^ 16'h5A5A and tracks stores.
module tb_dcache_nway;
    logic clk = 1'b0;
    logic rst;
    dcache_if bus();
`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] perf_hits, perf_misses;
    dcache_nway dut (.clk(clk), .rst(rst), .bus(bus), .perf_hits(perf_hits), .perf_misses(perf_misses));
`else
    dcache_nway dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int rd_cnt, wr_cnt, req_cyc, rdy_cnt, held, beats, k;
    logic [15:0] wr_addr, wr_data, q;
    logic [15:0] rd_q[$];
    logic [15:0] mem [32768];
    logic        pv [4];
    logic [15:0] pa [4];
    logic        grant_en;
    int lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rq, output int lt);
        @(posedge clk);
        #1;
        rd_cnt = 0; wr_cnt = 0; req_cyc = 0; rdy_cnt = 0;
        rd_q.delete();
        bus.cpu_req = 1'b1; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
        lt = 0;
        do begin
            @(negedge clk);
            lt++;
        end while (!bus.cpu_ready && lt < 500);
        check("ready", bus.cpu_ready, 1);
        rq = bus.cpu_rdata;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Memory: sample strobes mid-cycle, return each beat 4 cycles after its address.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2) ^ 16'h5A5A;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        forever begin
            logic iv;
            logic [15:0] ia, t;
            @(negedge clk);
            iv = bus.memory_read_en;
            ia = bus.memory_address;
            if (iv) begin rd_cnt++; rd_q.push_back(ia); end
            if (bus.memory_write_en) begin
                wr_cnt++;
                wr_addr = bus.memory_address;
                wr_data = bus.memory_data_out;
                mem[wr_addr[15:1]] = wr_data;
            end
            if (bus.mem_req) req_cyc++;
            if (bus.cpu_ready) rdy_cnt++;
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = iv; pa[0] = ia;
            t = pa[3];
            bus.memory_data_valid = pv[3];
            bus.memory_data_in = pv[3] ? mem[t[15:1]] : 16'h0;
            bus.mem_grant = bus.mem_req && grant_en;
        end
    end

    initial begin
        rst = 1'b1; grant_en = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.mem_grant = 0; bus.memory_data_valid = 0; bus.memory_data_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ready", bus.cpu_ready, 0);
        check("rst_addr", bus.memory_address, 0);
        rst = 1'b0;

        access(0, 16'h1234, 0, q, lat);
        check("cold_data", q, 16'h486E);
        check("cold_reads", rd_cnt, 8);
        check("cold_ready_cnt", rdy_cnt, 1);
        for (int i = 0; i < rd_q.size(); i++) check("fill_addr", rd_q[i], 16'h1230 + 16'(2 * i));
        access(0, 16'h1236, 0, q, lat);
        check("hit_data", q, 16'h486C);
        check("hit_lat", lat, 2);
        check("hit_no_req", req_cyc, 0);

        access(1, 16'h1234, 16'hBEEF, q, lat);
        check("wr_cnt", wr_cnt, 1);
        check("wr_addr", wr_addr, 16'h1234);
        check("wr_data", wr_data, 16'hBEEF);
        check("wr_no_fill", rd_cnt, 0);
        access(0, 16'h1234, 0, q, lat);
        check("rb_data", q, 16'hBEEF);
        check("rb_no_fill", rd_cnt, 0);
        check("rb_lat", lat, 2);

        access(1, 16'h4000, 16'h1111, q, lat);
        check("wmiss_reads", rd_cnt, 8);
        check("wmiss_writes", wr_cnt, 1);
        check("wmiss_data", wr_data, 16'h1111);
        access(0, 16'h4002, 0, q, lat);
        check("wmiss_neighbor", q, 16'h1A58);
        check("wmiss_nb_lat", lat, 2);
        access(0, 16'h4000, 0, q, lat);
        check("wmiss_merged", q, 16'h1111);

        grant_en = 1'b0;
        held = 0;
        fork
            access(0, 16'h2000, 0, q, lat);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!bus.mem_req && k < 50);
                for (int j = 0; j < 10; j++) begin
                    if (bus.mem_req && !bus.memory_read_en) held++;
                    @(negedge clk);
                end
                grant_en = 1'b1;
            end
        join
        check("nogrant_held", held, 10);
        check("grant_data", q, 16'h7A5A);
        check("grant_reads", rd_cnt, 8);

        @(posedge clk);
        #1 bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3234;
        beats = 0; k = 0;
        while (beats < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (bus.memory_data_valid) beats++;
        end
        check("third_beat", beats, 3);
        rst = 1'b1; bus.cpu_req = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_req", bus.mem_req, 0);
        check("mid_rst_rden", bus.memory_read_en, 0);
        check("mid_rst_addr", bus.memory_address, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_cnt = 0;
        repeat (10) @(negedge clk);
        check("post_rst_idle", bus.busy, 0);
        check("post_rst_noready", rdy_cnt, 0);
        access(0, 16'h1234, 0, q, lat);
        check("post_rst_refill", rd_cnt, 8);
        check("post_rst_data", q, 16'hBEEF);

        pulse_rst();
        access(0, 16'h1234, 0, q, lat);
        check("lru1_reads", rd_cnt, 8);
        access(0, 16'h1634, 0, q, lat);
        check("lru2_reads", rd_cnt, 8);
        check("lru2_data", q, 16'h4C6E);
        access(0, 16'h1234, 0, q, lat);
        check("lru3_hit", rd_cnt, 0);
        access(0, 16'h1A34, 0, q, lat);
        check("lru4_reads", rd_cnt, 8);
        check("lru4_data", q, 16'h406E);
        access(0, 16'h1234, 0, q, lat);
        check("lru5_hit", rd_cnt, 0);
        check("lru5_data", q, 16'hBEEF);
        access(0, 16'h1634, 0, q, lat);
        check("lru6_evicted", rd_cnt, 8);
        check("lru6_data", q, 16'h4C6E);
`ifdef DCACHE_PERF_CNT_EN
        check("perf_hits", perf_hits, 2);
        check("perf_misses", perf_misses, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
